// File: rtl/seven_segment_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with anti-ghost blanking,
// frame-synchronous (tear-free) data latching and leading-zero suppression.

module seven_segment (
  input  logic [3:0] Binary_Num,
  output logic [6:0] Segment
);
  // Segment bit order {g,f,e,d,c,b,a}, active-high; non-BCD codes show a dash.
  always_comb begin
    case (Binary_Num)
      4'd0:    Segment = 7'h3F;
      4'd1:    Segment = 7'h06;
      4'd2:    Segment = 7'h5B;
      4'd3:    Segment = 7'h4F;
      4'd4:    Segment = 7'h66;
      4'd5:    Segment = 7'h6D;
      4'd6:    Segment = 7'h7D;
      4'd7:    Segment = 7'h07;
      4'd8:    Segment = 7'h7F;
      4'd9:    Segment = 7'h6F;
      default: Segment = 7'h40;
    endcase
  end
endmodule

module seven_segment_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 1000,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter int unsigned IDX_W        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    lz_blank_en,
  output logic [6:0]              Segment,
  output logic [NUM_DIGITS-1:0]   Digit_En,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_done
);
  localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic {S_BLANK, S_SHOW} state_t;

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic [IDX_W-1:0]        idx_nx;
  logic [4*NUM_DIGITS-1:0] pending, shadow;
  logic [3:0]              nibble;
  logic [6:0]              dec_seg;
  logic                    seg_blank;
  logic                    zero_acc;
  logic                    last_digit;
  logic [6:0]              seg_nx;
  logic [NUM_DIGITS-1:0]   en_nx;
  logic                    fd_nx;

  seven_segment u_dec (
    .Binary_Num (nibble),
    .Segment    (dec_seg)
  );

  // Select the current digit's nibble and decide leading-zero blanking:
  // zero_acc tracks "all digits from here up to the MSD are zero".
  always_comb begin
    nibble    = '0;
    seg_blank = 1'b0;
    zero_acc  = 1'b1;
    for (int unsigned i = NUM_DIGITS; i > 0; i--) begin
      zero_acc = zero_acc & (shadow[4*(i-1) +: 4] == 4'd0);
      if (digit_idx == IDX_W'(i-1)) begin
        nibble    = shadow[4*(i-1) +: 4];
        seg_blank = lz_blank_en & zero_acc & (i > 1);
      end
    end
  end

  assign last_digit = (digit_idx == IDX_W'(NUM_DIGITS-1));

  // Outputs are computed for the next state and registered, so Segment and
  // Digit_En always switch together on the state-change edge.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CNT_W'(1);
    idx_nx   = digit_idx;
    seg_nx   = '0;
    en_nx    = '0;
    fd_nx    = 1'b0;
    case (state)
      S_BLANK: begin
        if (cnt == CNT_W'(BLANK_CYCLES-1)) begin
          state_nx = S_SHOW;
          cnt_nx   = '0;
          en_nx    = NUM_DIGITS'(1) << digit_idx;
          seg_nx   = seg_blank ? 7'h00 : dec_seg;
          fd_nx    = (REFRESH_DIV == 1) && last_digit;
        end
      end
      S_SHOW: begin
        if (cnt == CNT_W'(REFRESH_DIV-1)) begin
          state_nx = S_BLANK;
          cnt_nx   = '0;
          idx_nx   = last_digit ? '0 : digit_idx + IDX_W'(1);
        end else begin
          seg_nx = Segment;
          en_nx  = Digit_En;
          fd_nx  = (cnt_nx == CNT_W'(REFRESH_DIV-1)) && last_digit;
        end
      end
      default: state_nx = S_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_BLANK;
      cnt        <= '0;
      digit_idx  <= '0;
      Segment    <= '0;
      Digit_En   <= '0;
      frame_done <= 1'b0;
      pending    <= '0;
      shadow     <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      digit_idx  <= idx_nx;
      Segment    <= seg_nx;
      Digit_En   <= en_nx;
      frame_done <= fd_nx;
      if (load)
        pending <= data_in;
      // frame_done marks the last show cycle, so shadow swaps between frames.
      if (frame_done)
        shadow <= pending;
    end
  end
endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Directed bench for seven_segment_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=4,
// BLANK_CYCLES=1 (20-cycle frame).

module tb_seven_segment_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data_in;
  logic        lz_blank_en;
  logic [6:0]  Segment;
  logic [3:0]  Digit_En;
  logic [1:0]  digit_idx;
  logic        frame_done;
  logic [13:0] obs;

  int total = 0;
  int bad   = 0;
  int c     = 0;

  seven_segment_scan_ctrl #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1),
    .IDX_W        (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .data_in     (data_in),
    .lz_blank_en (lz_blank_en),
    .Segment     (Segment),
    .Digit_En    (Digit_En),
    .digit_idx   (digit_idx),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  assign obs = {frame_done, digit_idx, Digit_En, Segment};

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Cycle c counts edges since reset release; each slot is 1 blank + 4 show cycles.
  function automatic logic [13:0] exp_vec(input int cyc, input logic [15:0] d, input logic lz);
    int p, slot, w;
    logic [3:0] nib, en;
    logic [6:0] s;
    logic blank, fd;
    p     = cyc % 20;
    slot  = p / 5;
    w     = p % 5;
    nib   = d[4*slot +: 4];
    en    = (w == 0) ? 4'b0000 : 4'(1 << slot);
    blank = lz && (slot > 0) && ((d >> (4*slot)) == 16'h0000);
    s     = ((w == 0) || blank) ? 7'h00 : seg_of(nib);
    fd    = (p == 19);
    return {fd, 2'(slot), en, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; data_in = '0; lz_blank_en = 1'b0;
    repeat (3) tick();
    total++;
    if (obs !== 14'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=%h", obs, 14'h0);
    end
    rst = 1'b0;
    c = 0;
    total++;
    if (obs !== 14'h0) begin
      bad++;
      $display("FAIL reset_first_blank got=%h exp=%h", obs, 14'h0);
    end
    tick();
    total++;
    if (obs !== {1'b0, 2'd0, 4'b0001, 7'h3F}) begin
      bad++;
      $display("FAIL reset_first_show got=%h exp=%h", obs, {1'b0, 2'd0, 4'b0001, 7'h3F});
    end
  endtask

  task automatic test_scan();
    load = 1'b1; data_in = 16'h4321;
    tick();
    load = 1'b0;
    while (c <= 59) begin
      total++;
      if (obs !== exp_vec(c, (c < 20) ? 16'h0000 : 16'h4321, 1'b0)) begin
        bad++;
        $display("FAIL scan c=%0d got=%h exp=%h", c, obs, exp_vec(c, (c < 20) ? 16'h0000 : 16'h4321, 1'b0));
      end
      if (c < 59) tick(); else break;
    end
  endtask

  task automatic test_tear_free();
    while (c < 65) tick();
    load = 1'b1; data_in = 16'h1234;
    tick();
    load = 1'b0;
    tick();
    load = 1'b1; data_in = 16'h5678;
    tick();
    load = 1'b0;
    while (c <= 99) begin
      total++;
      if (obs !== exp_vec(c, (c < 80) ? 16'h4321 : 16'h5678, 1'b0)) begin
        bad++;
        $display("FAIL tear_free c=%0d got=%h exp=%h", c, obs, exp_vec(c, (c < 80) ? 16'h4321 : 16'h5678, 1'b0));
      end
      if (c < 99) tick(); else break;
    end
  endtask

  task automatic test_load_on_frame_done();
    total++;
    if (frame_done !== 1'b1) begin
      bad++;
      $display("FAIL fd_cycle got=%b exp=%b", frame_done, 1'b1);
    end
    load = 1'b1; data_in = 16'h9087;
    tick();
    load = 1'b0;
    while (c <= 139) begin
      total++;
      if (obs !== exp_vec(c, (c < 120) ? 16'h5678 : 16'h9087, 1'b0)) begin
        bad++;
        $display("FAIL load_on_fd c=%0d got=%h exp=%h", c, obs, exp_vec(c, (c < 120) ? 16'h5678 : 16'h9087, 1'b0));
      end
      if (c < 139) tick(); else break;
    end
  endtask

  task automatic test_leading_zero();
    logic [15:0] d;
    lz_blank_en = 1'b1;
    tick();
    load = 1'b1; data_in = 16'h0050;
    tick();
    load = 1'b0;
    while (c < 160) tick();
    load = 1'b1; data_in = 16'h0000;
    tick();
    load = 1'b0;
    c = c;
    while (c <= 199) begin
      d = (c < 160) ? 16'h9087 : (c < 180) ? 16'h0050 : 16'h0000;
      total++;
      if (obs !== exp_vec(c, d, 1'b1)) begin
        bad++;
        $display("FAIL leading_zero c=%0d got=%h exp=%h", c, obs, exp_vec(c, d, 1'b1));
      end
      if (c < 199) tick(); else break;
    end
  endtask

  task automatic test_nonbcd_and_reset();
    lz_blank_en = 1'b0;
    tick();
    load = 1'b1; data_in = 16'h0A00;
    tick();
    load = 1'b0;
    while (c <= 232) begin
      total++;
      if (obs !== exp_vec(c, (c < 220) ? 16'h0000 : 16'h0A00, 1'b0)) begin
        bad++;
        $display("FAIL nonbcd c=%0d got=%h exp=%h", c, obs, exp_vec(c, (c < 220) ? 16'h0000 : 16'h0A00, 1'b0));
      end
      if (c < 232) tick(); else break;
    end
    total++;
    if (Segment !== 7'h40) begin
      bad++;
      $display("FAIL nonbcd_pattern got=%h exp=%h", Segment, 7'h40);
    end
    rst = 1'b1;
    tick();
    total++;
    if (obs !== 14'h0) begin
      bad++;
      $display("FAIL mid_show_reset got=%h exp=%h", obs, 14'h0);
    end
    rst = 1'b0;
    c = 0;
    while (c <= 7) begin
      total++;
      if (obs !== exp_vec(c, 16'h0000, 1'b0)) begin
        bad++;
        $display("FAIL restart c=%0d got=%h exp=%h", c, obs, exp_vec(c, 16'h0000, 1'b0));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tear_free();
    test_load_on_frame_done();
    test_leading_zero();
    test_nonbcd_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
